// File: rtl/bt656_pkg.sv
// Shared state encoding, configuration record and reset defaults for the
// BT.656 transmit sequencer.
package bt656_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic        DEF_INTERLACE   = 1'b1;
  localparam logic        DEF_FIRST_FIELD = 1'b1;
  localparam logic [15:0] DEF_FIRST_LINE  = 16'd523;

  typedef struct packed {
    logic        interlace;
    logic        firstField;
    logic [15:0] firstLine;
  } txCfg_t;

endpackage

// File: rtl/bt656_frame_tracker.sv
// Finds Vsignal rising edges, marks frame boundaries (every rise when
// progressive, every second rise when interlaced) and watches for lost sync.
module bt656_frame_tracker #(
  parameter int unsigned WDOG_CYCLES = 8000000
) (
  input  logic clock,
  input  logic reset,
  input  logic vsignal,
  input  logic interlace,
  input  logic run,
  output logic fb,
  output logic timeout
);

  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic              vD;
  logic              fieldTog;
  logic              vrise;
  logic [WDOG_W-1:0] wdog;

  assign vrise   = vsignal & ~vD;
  assign fb      = run & vrise & (~interlace | fieldTog);
  assign timeout = run & (wdog == WDOG_W'(WDOG_CYCLES - 1));

  // Outside RUN the toggle and watchdog sit at zero, so both start fresh
  // every time the stream (re)enters RUN.
  always_ff @(posedge clock) begin
    if (reset) begin
      vD       <= 1'b0;
      fieldTog <= 1'b0;
      wdog     <= '0;
    end else begin
      vD <= vsignal;
      if (!run) begin
        fieldTog <= 1'b0;
        wdog     <= '0;
      end else if (vrise) begin
        fieldTog <= ~fieldTog;
        wdog     <= '0;
      end else begin
        wdog <= wdog + WDOG_W'(1);
      end
    end
  end

endmodule

// File: rtl/bt656_tx_ctrl.sv
// Run-time sequencer for bt656_tx: start/stop and config changes land on
// frame boundaries through a TxValid-low gap; a watchdog faults lost vsync.
//
//   state | meaning
//   IDLE  | not streaming; config written straight to the outputs
//   RUN   | streaming; new config shadowed until the next frame boundary
//   GAP   | TxValid held low while a newly applied config settles
module bt656_tx_ctrl import bt656_pkg::*; #(
  parameter int unsigned GAP_CYCLES      = 16,
  parameter int unsigned WDOG_CYCLES     = 8000000,
  parameter logic        DEF_INTERLACE   = bt656_pkg::DEF_INTERLACE,
  parameter logic        DEF_FIRST_FIELD = bt656_pkg::DEF_FIRST_FIELD,
  parameter logic [15:0] DEF_FIRST_LINE  = bt656_pkg::DEF_FIRST_LINE
) (
  input  logic        i_SysClock,
  input  logic        i_Reset,
  input  logic        i_Start,
  input  logic        i_Stop,
  input  logic        i_CfgValid,
  output logic        o_CfgReady,
  input  logic        i_CfgInterlace,
  input  logic        i_CfgFirstField,
  input  logic [15:0] i_CfgFirstLine,
  input  logic        i_Vsignal,
  input  logic        i_Fsignal,
  output logic        o_TxValid,
  output logic        o_InterlaceMode,
  output logic        o_FirstField,
  output logic [15:0] o_FirstLine,
  output logic        o_Busy,
  output logic        o_FrameDone,
  output logic [15:0] o_FrameCount,
  output logic        o_Timeout
);

  localparam int     GAP_W     = $clog2(GAP_CYCLES + 1);
  localparam txCfg_t RESET_CFG = '{DEF_INTERLACE, DEF_FIRST_FIELD, DEF_FIRST_LINE};

  state_t             state, stateN;
  txCfg_t             cfgQ, cfgN, shadowQ, shadowN, cfgIn;
  logic               pendingQ, pendingN, stopReqQ, stopReqN;
  logic               txValidQ, txValidN, frameDoneQ, frameDoneN;
  logic               timeoutQ, timeoutN, cfgReadyQ, cfgReadyN, busyQ, busyN;
  logic [15:0]        frameCountQ, frameCountN;
  logic [GAP_W-1:0]   gapCntQ, gapCntN;
  logic               fb, wdogTimeout, cfgAccept;
  logic               unusedFsignal;

  assign unusedFsignal = i_Fsignal;
  assign cfgIn         = {i_CfgInterlace, i_CfgFirstField, i_CfgFirstLine};
  assign cfgAccept     = i_CfgValid & cfgReadyQ;

  bt656_frame_tracker #(.WDOG_CYCLES(WDOG_CYCLES)) tracker (
    .clock    (i_SysClock),
    .reset    (i_Reset),
    .vsignal  (i_Vsignal),
    .interlace(cfgQ.interlace),
    .run      (state == RUN),
    .fb       (fb),
    .timeout  (wdogTimeout)
  );

  always_ff @(posedge i_SysClock) begin
    if (i_Reset) begin
      state       <= IDLE;
      cfgQ        <= RESET_CFG;
      shadowQ     <= RESET_CFG;
      pendingQ    <= 1'b0;
      stopReqQ    <= 1'b0;
      txValidQ    <= 1'b0;
      frameDoneQ  <= 1'b0;
      frameCountQ <= '0;
      timeoutQ    <= 1'b0;
      cfgReadyQ   <= 1'b1;
      busyQ       <= 1'b0;
      gapCntQ     <= '0;
    end else begin
      state       <= stateN;
      cfgQ        <= cfgN;
      shadowQ     <= shadowN;
      pendingQ    <= pendingN;
      stopReqQ    <= stopReqN;
      txValidQ    <= txValidN;
      frameDoneQ  <= frameDoneN;
      frameCountQ <= frameCountN;
      timeoutQ    <= timeoutN;
      cfgReadyQ   <= cfgReadyN;
      busyQ       <= busyN;
      gapCntQ     <= gapCntN;
    end
  end

  always_comb begin
    stateN      = state;
    cfgN        = cfgQ;
    shadowN     = shadowQ;
    pendingN    = pendingQ;
    stopReqN    = stopReqQ;
    txValidN    = txValidQ;
    frameDoneN  = 1'b0;
    frameCountN = frameCountQ;
    timeoutN    = timeoutQ;
    gapCntN     = gapCntQ;
    case (state)
      IDLE: begin
        if (cfgAccept) cfgN = cfgIn;
        if (i_Start && !i_Stop) begin
          stateN      = RUN;
          txValidN    = 1'b1;
          frameCountN = '0;
          timeoutN    = 1'b0;
        end
      end
      RUN: begin
        if (cfgAccept) begin
          shadowN  = cfgIn;
          pendingN = 1'b1;
        end
        if (i_Stop) stopReqN = 1'b1;
        if (wdogTimeout) begin
          stateN   = IDLE;
          txValidN = 1'b0;
          timeoutN = 1'b1;
          stopReqN = 1'b0;
          pendingN = 1'b0;
        end else if (fb) begin
          frameDoneN  = 1'b1;
          frameCountN = frameCountQ + 16'd1;
          if (stopReqQ || i_Stop) begin
            stateN   = IDLE;
            txValidN = 1'b0;
            stopReqN = 1'b0;
            pendingN = 1'b0;
            // a config arriving on the boundary cycle must not be lost
            if (cfgAccept) cfgN = cfgIn;
            else if (pendingQ) cfgN = shadowQ;
          end else if (pendingQ) begin
            stateN   = GAP;
            txValidN = 1'b0;
            cfgN     = shadowQ;
            pendingN = 1'b0;
            gapCntN  = GAP_W'(GAP_CYCLES - 1);
          end
        end
      end
      GAP: begin
        if (i_Stop) stopReqN = 1'b1;
        if (gapCntQ == '0) begin
          if (stopReqQ || i_Stop) begin
            stateN   = IDLE;
            stopReqN = 1'b0;
          end else begin
            stateN   = RUN;
            txValidN = 1'b1;
          end
        end else begin
          gapCntN = gapCntQ - GAP_W'(1);
        end
      end
      default: stateN = IDLE;
    endcase
    cfgReadyN = (stateN == IDLE) | ((stateN == RUN) & ~pendingN);
    busyN     = (stateN != IDLE);
  end

  assign o_TxValid       = txValidQ;
  assign o_InterlaceMode = cfgQ.interlace;
  assign o_FirstField    = cfgQ.firstField;
  assign o_FirstLine     = cfgQ.firstLine;
  assign o_CfgReady      = cfgReadyQ;
  assign o_Busy          = busyQ;
  assign o_FrameDone     = frameDoneQ;
  assign o_FrameCount    = frameCountQ;
  assign o_Timeout       = timeoutQ;

endmodule

// File: tb/tb_bt656_tx_ctrl.sv
// Bench for bt656_tx_ctrl: random frame lengths and configs, with expected
// frame counts, gap lengths and stop latency derived from the frame rules.
module tb_bt656_tx_ctrl;

  localparam int GAP  = 16;
  localparam int WDOG = 100;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0;
  logic        cfgValid = 1'b0, cfgIl = 1'b0, cfgFf = 1'b0, vsig = 1'b0, fsig = 1'b0;
  logic [15:0] cfgFl = '0;
  logic        o_CfgReady, o_TxValid, o_InterlaceMode, o_FirstField;
  logic        o_Busy, o_FrameDone, o_Timeout;
  logic [15:0] o_FirstLine, o_FrameCount;

  int total = 0, bad = 0;
  int doneCnt = 0, lowRun = 0, lastLow = 0, gapSeen = 0;

  bt656_tx_ctrl #(.GAP_CYCLES(GAP), .WDOG_CYCLES(WDOG)) dut (
    .i_SysClock(clk), .i_Reset(rst), .i_Start(start), .i_Stop(stop),
    .i_CfgValid(cfgValid), .o_CfgReady(o_CfgReady), .i_CfgInterlace(cfgIl),
    .i_CfgFirstField(cfgFf), .i_CfgFirstLine(cfgFl), .i_Vsignal(vsig),
    .i_Fsignal(fsig), .o_TxValid(o_TxValid), .o_InterlaceMode(o_InterlaceMode),
    .o_FirstField(o_FirstField), .o_FirstLine(o_FirstLine), .o_Busy(o_Busy),
    .o_FrameDone(o_FrameDone), .o_FrameCount(o_FrameCount), .o_Timeout(o_Timeout)
  );

  always #5 clk = ~clk;

  // Count frame pulses and measure every busy-but-not-valid stretch.
  always @(negedge clk) begin
    if (o_FrameDone) doneCnt++;
    if (o_Busy && !o_TxValid) lowRun++;
    else if (lowRun != 0) begin
      lastLow = lowRun;
      gapSeen++;
      lowRun = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chkRst(input string p);
    chk({p, "_tx"}, o_TxValid, 0);
    chk({p, "_busy"}, o_Busy, 0);
    chk({p, "_fd"}, o_FrameDone, 0);
    chk({p, "_fc"}, o_FrameCount, 0);
    chk({p, "_to"}, o_Timeout, 0);
    chk({p, "_rdy"}, o_CfgReady, 1);
    chk({p, "_cfg"}, {o_InterlaceMode, o_FirstField, o_FirstLine}, {1'b1, 1'b1, 16'd523});
  endtask

  task automatic offerCfg(input logic il, input logic ff, input logic [15:0] fl);
    cfgValid = 1'b1; cfgIl = il; cfgFf = ff; cfgFl = fl;
    step(1);
    cfgValid = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1; step(1); start = 1'b0;
  endtask

  task automatic pulseStop();
    stop = 1'b1; step(1); stop = 1'b0;
  endtask

  // One Vsignal rise: 3 cycles high then lowLen low; reports outputs seen
  // right after the edge that samples the rise.
  task automatic vRise(input int lowLen, output logic fdR, output logic txR);
    vsig = 1'b1;
    step(1);
    fdR = o_FrameDone;
    txR = o_TxValid;
    step(2);
    vsig = 1'b0;
    step(lowLen);
  endtask

  logic        il, ff, fd, tx;
  logic [15:0] fl, fl1;
  int          n, need, cnt, base, gb, hi, expFrames;

  initial begin
    step(2);
    chkRst("rst");
    rst = 1'b0;
    step(1);

    // progressive streaming
    offerCfg(1'b0, 1'b0, 16'd0);
    chk("idle_cfg", {o_InterlaceMode, o_FirstField, o_FirstLine}, 18'd0);
    base = doneCnt;
    pulseStart();
    chk("start_lat", o_TxValid, 1);
    chk("start_busy", o_Busy, 1);
    for (int i = 0; i < 3; i++) begin
      vRise($urandom_range(20, 40), fd, tx);
      chk("pf_fd_lat", fd, 1);
    end
    chk("pf_done", doneCnt - base, 3);
    chk("pf_fc", o_FrameCount, 3);
    pulseStop();
    chk("pf_stop_wait", o_TxValid, 1);
    vRise(20, fd, tx);
    chk("pf_stop_tx_lat", tx, 0);
    chk("pf_stop_busy", o_Busy, 0);
    chk("pf_stop_fc", o_FrameCount, 4);

    // random configs and frame runs
    for (int r = 0; r < 4; r++) begin
      il = 1'($urandom_range(0, 1));
      ff = 1'($urandom_range(0, 1));
      fl = 16'($urandom_range(0, 65535));
      offerCfg(il, ff, fl);
      chk("rnd_cfg", {o_InterlaceMode, o_FirstField, o_FirstLine}, {il, ff, fl});
      base = doneCnt;
      pulseStart();
      chk("rnd_fc0", o_FrameCount, 0);
      n = $urandom_range(2, 6);
      for (int i = 0; i < n; i++) vRise($urandom_range(20, 40), fd, tx);
      expFrames = il ? n / 2 : n;
      chk("rnd_frames", doneCnt - base, expFrames);
      chk("rnd_fc", o_FrameCount, expFrames);
      pulseStop();
      need = (il && (n % 2 == 0)) ? 2 : 1;
      cnt = 0;
      while (o_Busy && cnt < 4) begin
        vRise($urandom_range(20, 40), fd, tx);
        cnt++;
      end
      chk("rnd_stop_rises", cnt, need);
      chk("rnd_stop_fc", o_FrameCount, expFrames + 1);
      chk("rnd_stop_tx", o_TxValid, 0);
    end

    // mid-frame config change through a gap
    offerCfg(1'b0, 1'b1, 16'd100);
    pulseStart();
    vRise(25, fd, tx);
    fl1 = 16'($urandom_range(0, 65535));
    offerCfg(1'b0, 1'b0, fl1);
    chk("gap_rdy_drop", o_CfgReady, 0);
    chk("gap_cfg_hold", {o_InterlaceMode, o_FirstField, o_FirstLine}, {1'b0, 1'b1, 16'd100});
    cfgValid = 1'b1; cfgIl = 1'b1; cfgFf = 1'b1; cfgFl = ~fl1;
    step(3);
    chk("gap_refuse", o_CfgReady, 0);
    cfgValid = 1'b0;
    gb = gapSeen;
    vRise(30, fd, tx);
    chk("gap_tx_lat", tx, 0);
    chk("gap_fd", fd, 1);
    chk("gap_seen", gapSeen - gb, 1);
    chk("gap_len", lastLow, GAP);
    chk("gap_cfg_new", {o_InterlaceMode, o_FirstField, o_FirstLine}, {1'b0, 1'b0, fl1});
    chk("gap_tx_back", o_TxValid, 1);
    chk("gap_rdy_back", o_CfgReady, 1);
    vRise(25, fd, tx);
    chk("gap_no_second", gapSeen - gb, 1);
    chk("gap_cfg_kept", {o_InterlaceMode, o_FirstField, o_FirstLine}, {1'b0, 1'b0, fl1});

    // stop with a pending config
    fl = 16'($urandom_range(0, 65535));
    offerCfg(1'b1, 1'b1, fl);
    pulseStop();
    step(5);
    chk("sp_tx_hold", o_TxValid, 1);
    chk("sp_cfg_hold", {o_InterlaceMode, o_FirstLine}, {1'b0, fl1});
    base = doneCnt;
    vRise(20, fd, tx);
    chk("sp_busy", o_Busy, 0);
    chk("sp_tx", o_TxValid, 0);
    chk("sp_done", doneCnt - base, 1);
    chk("sp_cfg", {o_InterlaceMode, o_FirstField, o_FirstLine}, {1'b1, 1'b1, fl});

    // watchdog (interlace config still active)
    pulseStart();
    vRise(20, fd, tx);
    vRise(20, fd, tx);
    chk("wd_fc_pre", o_FrameCount, 1);
    cnt = 0;
    while (!o_Timeout && cnt < 400) begin
      step(1);
      cnt++;
    end
    chk("wd_fire", o_Timeout, 1);
    chk("wd_tx", o_TxValid, 0);
    chk("wd_busy", o_Busy, 0);
    chk("wd_fc_hold", o_FrameCount, 1);
    pulseStart();
    chk("wd_to_clr", o_Timeout, 0);
    chk("wd_fc_clr", o_FrameCount, 0);
    hi = 0;
    while (o_TxValid && hi < 300) begin
      hi++;
      step(1);
    end
    chk("wd_len", hi, WDOG);
    chk("wd_fire2", o_Timeout, 1);

    // reset while in GAP
    offerCfg(1'b0, 1'b0, 16'd7);
    pulseStart();
    step(5);
    offerCfg(1'b1, 1'b0, 16'd9);
    vsig = 1'b1;
    step(5);
    vsig = 1'b0;
    chk("rg_in_gap", {o_Busy, o_TxValid}, 2'b10);
    rst = 1'b1;
    step(1);
    chkRst("rg");
    rst = 1'b0;
    step(2);

    // frame counter wrap
    offerCfg(1'b0, 1'b0, 16'd0);
    pulseStart();
    force dut.frameCountQ = 16'hFFFF;
    step(2);
    release dut.frameCountQ;
    step(1);
    chk("wrap_pre", o_FrameCount, 16'hFFFF);
    base = doneCnt;
    vRise(20, fd, tx);
    chk("wrap_fd", fd, 1);
    chk("wrap_fc", o_FrameCount, 0);
    chk("wrap_done", doneCnt - base, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
